// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and the write beat payload.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Latched write-data beat.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axil_wbeat_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file: NCTRL R/W control words, NSTAT RO status words, one RO ID word.
// Ports:
//   clk, rst                      clock, async active-high reset
//   s_axi_aw*/w*/b*               write address / data / response channels
//   s_axi_ar*/r*                  read address / data channels
//   ctrl_o                        control words, flattened (word k at [32k+31:32k])
//   ctrl_wr_o                     one-cycle pulse per control word when it is written
//   stat_i                        status words, flattened, sampled at the AR handshake
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned NCTRL     = 8,
    parameter int unsigned NSTAT     = 8,
    parameter logic [31:0] ID_VALUE  = 32'h5A7E_0001,
    parameter logic [31:0] CTRL_INIT = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [32*NCTRL-1:0]   ctrl_o,
    output logic [NCTRL-1:0]      ctrl_wr_o,
    input  logic [32*NSTAT-1:0]   stat_i
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned ID_IDX = NCTRL + NSTAT;

    // The whole map must fit in the word-index space.
    generate
        if (NCTRL + NSTAT + 1 > (1 << IDX_W)) begin : g_map_too_big
            $error("axi_lite_regfile: register map does not fit in ADDR_W");
        end
    endgenerate

    // Byte-lane bits of the address do not select anything.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ---------------- write path ----------------
    wr_state_t                w_state, w_state_n;
    logic                     aw_held, aw_held_n, w_held, w_held_n;
    logic [IDX_W-1:0]         aw_idx, aw_idx_n;
    axil_wbeat_t              w_beat, w_beat_n;
    logic                     awready_n, wready_n, bvalid_n;
    logic [1:0]               bresp_n;
    logic [NCTRL-1:0][31:0]   ctrl_q, ctrl_n;
    logic [NCTRL-1:0]         ctrl_wr_n;

    assign ctrl_o = ctrl_q;

    // Write FSM next state: collect AW and W independently, then commit and respond.
    always_comb begin
        w_state_n = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        aw_idx_n  = aw_idx;
        w_beat_n  = w_beat;
        awready_n = s_axi_awready;
        wready_n  = s_axi_wready;
        bvalid_n  = s_axi_bvalid;
        bresp_n   = s_axi_bresp;
        ctrl_n    = ctrl_q;
        ctrl_wr_n = '0;
        case (w_state)
            W_IDLE: begin
                if (aw_held && w_held) begin
                    bresp_n = RESP_SLVERR;
                    for (int k = 0; k < NCTRL; k++) begin
                        if (aw_idx == IDX_W'(k)) begin
                            for (int b = 0; b < 4; b++) begin
                                if (w_beat.strb[b]) ctrl_n[k][8*b +: 8] = w_beat.data[8*b +: 8];
                            end
                            ctrl_wr_n[k] = 1'b1;
                            bresp_n      = RESP_OKAY;
                        end
                    end
                    bvalid_n  = 1'b1;
                    w_state_n = W_RESP;
                end else begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        aw_held_n = 1'b1;
                        aw_idx_n  = s_axi_awaddr[ADDR_W-1:2];
                    end
                    if (s_axi_wvalid && s_axi_wready) begin
                        w_held_n = 1'b1;
                        w_beat_n = '{data: s_axi_wdata, strb: s_axi_wstrb};
                    end
                    awready_n = ~aw_held_n;
                    wready_n  = ~w_held_n;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_n  = 1'b0;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            w_beat        <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            ctrl_q        <= {NCTRL{CTRL_INIT}};
            ctrl_wr_o     <= '0;
        end else begin
            w_state       <= w_state_n;
            aw_held       <= aw_held_n;
            w_held        <= w_held_n;
            aw_idx        <= aw_idx_n;
            w_beat        <= w_beat_n;
            s_axi_awready <= awready_n;
            s_axi_wready  <= wready_n;
            s_axi_bvalid  <= bvalid_n;
            s_axi_bresp   <= bresp_n;
            ctrl_q        <= ctrl_n;
            ctrl_wr_o     <= ctrl_wr_n;
        end
    end

    // ---------------- read path ----------------
    rd_state_t        r_state, r_state_n;
    logic [IDX_W-1:0] ar_idx;
    logic             arready_n, rvalid_n;
    logic [31:0]      rdata_n;
    logic [1:0]       rresp_n;

    assign ar_idx = s_axi_araddr[ADDR_W-1:2];

    // Read FSM next state: decode and capture at the AR handshake, hold until rready.
    // Uses ctrl_q, so a same-edge write is not visible to this read.
    always_comb begin
        r_state_n = r_state;
        arready_n = s_axi_arready;
        rvalid_n  = s_axi_rvalid;
        rdata_n   = s_axi_rdata;
        rresp_n   = s_axi_rresp;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (s_axi_arvalid && s_axi_arready) begin
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    r_state_n = R_DATA;
                    rdata_n   = '0;
                    rresp_n   = RESP_SLVERR;
                    for (int k = 0; k < NCTRL; k++) begin
                        if (ar_idx == IDX_W'(k)) begin
                            rdata_n = ctrl_q[k];
                            rresp_n = RESP_OKAY;
                        end
                    end
                    for (int k = 0; k < NSTAT; k++) begin
                        if (ar_idx == IDX_W'(NCTRL + k)) begin
                            rdata_n = stat_i[32*k +: 32];
                            rresp_n = RESP_OKAY;
                        end
                    end
                    if (ar_idx == IDX_W'(ID_IDX)) begin
                        rdata_n = ID_VALUE;
                        rresp_n = RESP_OKAY;
                    end
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            r_state       <= r_state_n;
            s_axi_arready <= arready_n;
            s_axi_rvalid  <= rvalid_n;
            s_axi_rdata   <= rdata_n;
            s_axi_rresp   <= rresp_n;
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed steps plus randomized traffic
// against a register-map reference model.
module tb_axi_lite_regfile;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned NCTRL     = 8;
    localparam int unsigned NSTAT     = 8;
    localparam logic [31:0] ID_VALUE  = 32'h5A7E_0001;
    localparam logic [31:0] CTRL_INIT = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [32*NCTRL-1:0] ctrl_o;
    logic [NCTRL-1:0]    ctrl_wr;
    logic [NSTAT-1:0][31:0] stat_m = '0;

    // reference model
    logic [31:0] ctrl_m [NCTRL];

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    axi_lite_regfile #(.ADDR_W(ADDR_W), .NCTRL(NCTRL), .NSTAT(NSTAT),
                       .ID_VALUE(ID_VALUE), .CTRL_INIT(CTRL_INIT)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr), .stat_i(stat_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCTRL; k++) ctrl_m[k] = CTRL_INIT;
    endtask

    // Expected write outcome from the register map; updates the model.
    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp, output logic [NCTRL-1:0] pulse);
        int idx;
        logic [31:0] mask;
        idx = int'(a) / 4;
        pulse = '0;
        if (idx < NCTRL) begin
            mask = 0;
            for (int b = 0; b < 4; b++) if (s[b]) mask = mask + (32'hFF << (8 * b));
            ctrl_m[idx] = (ctrl_m[idx] & ~mask) | (d & mask);
            pulse = NCTRL'(1) << idx;
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int idx;
        idx = int'(a) / 4;
        resp = 2'b00;
        if (idx < NCTRL)                d = ctrl_m[idx];
        else if (idx < NCTRL + NSTAT)   d = stat_m[idx - NCTRL];
        else if (idx == NCTRL + NSTAT)  d = ID_VALUE;
        else begin d = 0; resp = 2'b10; end
    endtask

    task automatic check_ctrl(input string tag);
        for (int k = 0; k < NCTRL; k++)
            chk($sformatf("%s_ctrl%0d", tag, k), ctrl_o[32*k +: 32], ctrl_m[k]);
    endtask

    task automatic wr(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int aw_dly, input int w_dly, input int b_dly);
        int cyc, lat;
        bit aw_done, w_done, aw_hs, w_hs;
        logic [1:0] eresp;
        logic [NCTRL-1:0] epulse;
        cyc = 0; aw_done = 0; w_done = 0;
        model_write(a, d, s, eresp, epulse);
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 64) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            cyc++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
        end
        awvalid = 0; wvalid = 0;
        chk({tag, "_handshake"}, 32'(aw_done && w_done), 1);
        lat = 0;
        while (!bvalid && lat < 16) begin tick(); lat++; end
        chk({tag, "_blat"}, 32'(lat), 1);
        chk({tag, "_bresp"}, 32'(bresp), 32'(eresp));
        chk({tag, "_pulse"}, 32'(ctrl_wr), 32'(epulse));
        check_ctrl(tag);
        for (int i = 0; i < b_dly; i++) begin
            tick();
            chk($sformatf("%s_bhold%0d", tag, i), 32'({bvalid, bresp}), 32'({1'b1, eresp}));
        end
        bready = 1;
        tick();
        bready = 0;
        chk({tag, "_bdone"}, 32'(bvalid), 0);
        chk({tag, "_pulse_end"}, 32'(ctrl_wr), 0);
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input int ar_dly,
                      input int r_dly, output logic [31:0] obs);
        int cyc;
        bit done, hs;
        logic [31:0] ed;
        logic [1:0]  er;
        cyc = 0; done = 0; ed = 0; er = 0;
        araddr = a;
        while (!done && cyc < 64) begin
            arvalid = (cyc >= ar_dly);
            hs = arvalid && arready;
            if (hs) model_read(a, ed, er);
            tick();
            cyc++;
            if (hs) done = 1;
        end
        arvalid = 0;
        chk({tag, "_handshake"}, 32'(done), 1);
        chk({tag, "_rvalid"}, 32'(rvalid), 1);
        // status inputs move after the sample point; the captured value must hold
        for (int i = 0; i < r_dly; i++) begin
            stat_m[i % NSTAT] = $urandom;
            tick();
            chk($sformatf("%s_rhold%0d", tag, i), 32'(rvalid), 1);
        end
        chk({tag, "_rdata"}, rdata, ed);
        chk({tag, "_rresp"}, 32'(rresp), 32'(er));
        obs = rdata;
        rready = 1;
        tick();
        rready = 0;
        chk({tag, "_rdone"}, 32'(rvalid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [ADDR_W-1:0] a;
        int sel;
        model_reset();

        // reset state
        tick(); tick();
        chk("rst_readys", 32'({awready, wready, arready}), 0);
        chk("rst_valids", 32'({bvalid, rvalid}), 0);
        chk("rst_resps", 32'({bresp, rresp}), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_pulse", 32'(ctrl_wr), 0);
        check_ctrl("rst");
        rst = 0;
        chk("rst_rel_readys", 32'({awready, wready, arready}), 0);
        tick();
        chk("post_rst_readys", 32'({awready, wready, arready}), 3'b111);

        // AW three cycles ahead of W
        wr("aw_first", 12'h004, 32'hCAFEF00D, 4'hF, 0, 3, 0);
        chk("word1_const", ctrl_o[63:32], 32'hCAFEF00D);

        // W first, then both together
        wr("w_first", 12'h000, 32'h01020304, 4'hF, 2, 0, 0);
        wr("aw_w_same", 12'h000, 32'h11223344, 4'hF, 0, 0, 0);

        // partial strobes
        wr("strb0101", 12'h001, 32'hAABBCCDD, 4'b0101, 1, 0, 0);
        rd("rd_strb", 12'h000, 0, 0, v);
        chk("strb_const", v, 32'h11BB33DD);

        // zero strobe: OKAY, pulse, no change
        wr("strb0", 12'h008, $urandom, 4'h0, 0, 1, 0);

        // status word sampling and write to a status word
        stat_m[0] = 32'h12345678;
        rd("rd_stat0", 12'h020, 1, 3, v);
        chk("stat0_const", v, 32'h12345678);
        wr("wr_stat0", 12'h020, 32'hDEADBEEF, 4'hF, 0, 0, 0);

        // ID, out-of-range, held response
        rd("rd_id", 12'h040, 0, 2, v);
        chk("id_const", v, ID_VALUE);
        rd("rd_oor", 12'hFFC, 0, 0, v);
        chk("oor_const", v, 0);
        wr("wr_oor", 12'h044, 32'h0000FFFF, 4'hF, 0, 0, 5);
        wr("bhold_ok", 12'h01C, 32'h76543210, 4'hF, 0, 0, 5);

        // read and write of the same word on the same edge
        wr("pre_same", 12'h014, 32'h5555AAAA, 4'hF, 0, 0, 0);
        awaddr = 12'h014; wdata = 32'h0BADBEEF; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        araddr = 12'h014; arvalid = 1;
        tick();
        arvalid = 0;
        chk("same_rvalid", 32'(rvalid), 1);
        chk("same_bvalid", 32'(bvalid), 1);
        chk("same_rdata_old", rdata, 32'h5555AAAA);
        chk("same_word5_new", ctrl_o[32*5 +: 32], 32'h0BADBEEF);
        ctrl_m[5] = 32'h0BADBEEF;
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        chk("same_done", 32'({bvalid, rvalid}), 0);

        // reset while a write response is pending
        awaddr = 12'h008; wdata = 32'h00000055; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        chk("mid_bvalid", 32'(bvalid), 1);
        chk("mid_word2", ctrl_o[32*2 +: 32], 32'h55);
        rst = 1;
        #1;
        chk("mid_rst_bvalid", 32'(bvalid), 0);
        chk("mid_rst_readys", 32'({awready, wready, arready}), 0);
        model_reset();
        check_ctrl("mid_rst");
        tick();
        rst = 0;
        tick();
        wr("after_rst", 12'h008, 32'h00000066, 4'hF, 0, 0, 0);
        rd("after_rst_rd", 12'h008, 0, 0, v);
        chk("after_rst_const", v, 32'h66);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(9, 0);
            if (sel == 9) a = ADDR_W'($urandom_range(1023, NCTRL + NSTAT + 1) * 4 + $urandom_range(3, 0));
            else          a = ADDR_W'($urandom_range(NCTRL + NSTAT, 0) * 4 + $urandom_range(3, 0));
            if ($urandom_range(3, 0) == 0) stat_m[$urandom_range(NSTAT - 1, 0)] = $urandom;
            if ($urandom_range(1, 0) == 1)
                wr($sformatf("rnd%0d_w", i), a, $urandom, 4'($urandom), $urandom_range(3, 0),
                   $urandom_range(3, 0), $urandom_range(2, 0));
            else
                rd($sformatf("rnd%0d_r", i), a, $urandom_range(3, 0), $urandom_range(2, 0), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
